// File: rtl/pll_lock_reset_ctrl.sv
// Reset sequencer driven by the CCC PLL lock: waits for stable lock, releases the
// fabric reset, then the core reset, and re-asserts both on lock loss or external reset.
module pll_lock_reset_ctrl #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int CORE_DELAY_CYCLES  = 16,
  parameter int LOSS_CNT_W         = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  PLL_LOCK,
  input  logic                  EXT_RST_N,
  input  logic                  CLR_LOST,
  output logic                  FABRIC_RESET_N,
  output logic                  CORE_RESET_N,
  output logic                  LOCK_LOST,
  output logic [LOSS_CNT_W-1:0] LOSS_COUNT
);

  localparam int CNT_MAX = (LOCK_STABLE_CYCLES > CORE_DELAY_CYCLES) ?
                           LOCK_STABLE_CYCLES : CORE_DELAY_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CORE_LAST   = CNT_W'(CORE_DELAY_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    FAB_REL   = 2'd2,
    RUN       = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic [SYNC_STAGES-1:0] ext_sync_q;
  logic                   lock_s;
  logic                   ext_s;
  logic                   ok;
  logic                   loss_event;

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   fab_rst_n_q;
  logic                   core_rst_n_q;
  logic                   lock_lost_q;
  logic [LOSS_CNT_W-1:0]  loss_cnt_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      lock_sync_q <= '0;
      ext_sync_q  <= '0;
    end else begin
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], PLL_LOCK};
      ext_sync_q  <= {ext_sync_q[SYNC_STAGES-2:0], EXT_RST_N};
    end
  end

  assign lock_s = lock_sync_q[SYNC_STAGES-1];
  assign ext_s  = ext_sync_q[SYNC_STAGES-1];
  assign ok     = lock_s & ext_s;

  // Only a lock drop after fabric release is a loss; external reset alone is not.
  assign loss_event = ((state_q == FAB_REL) || (state_q == RUN)) && !lock_s;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= WAIT_LOCK;
      cnt_q        <= '0;
      fab_rst_n_q  <= 1'b0;
      core_rst_n_q <= 1'b0;
      lock_lost_q  <= 1'b0;
      loss_cnt_q   <= '0;
    end else begin
      if (loss_event) begin
        lock_lost_q <= 1'b1;
      end else if (CLR_LOST) begin
        lock_lost_q <= 1'b0;
      end

      if (loss_event && (loss_cnt_q != '1)) begin
        loss_cnt_q <= loss_cnt_q + LOSS_CNT_W'(1);
      end

      case (state_q)
        WAIT_LOCK: begin
          cnt_q        <= '0;
          fab_rst_n_q  <= 1'b0;
          core_rst_n_q <= 1'b0;
          if (ok) begin
            state_q <= STABLE;
          end
        end
        STABLE: begin
          if (!ok) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_q     <= FAB_REL;
            cnt_q       <= '0;
            fab_rst_n_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        FAB_REL, RUN: begin
          // Dropping out of service asserts both resets on the same edge.
          if (!ok) begin
            state_q      <= WAIT_LOCK;
            cnt_q        <= '0;
            fab_rst_n_q  <= 1'b0;
            core_rst_n_q <= 1'b0;
          end else if (state_q == FAB_REL) begin
            if (cnt_q == CORE_LAST) begin
              state_q      <= RUN;
              cnt_q        <= '0;
              core_rst_n_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_q      <= WAIT_LOCK;
          cnt_q        <= '0;
          fab_rst_n_q  <= 1'b0;
          core_rst_n_q <= 1'b0;
        end
      endcase
    end
  end

  assign FABRIC_RESET_N = fab_rst_n_q;
  assign CORE_RESET_N   = core_rst_n_q;
  assign LOCK_LOST      = lock_lost_q;
  assign LOSS_COUNT     = loss_cnt_q;

endmodule
